poly_horner_pipe: RTL
=====================

Name: poly_horner_pipe

Overview:
- Parametrised fixed-point polynomial evaluator of selectable order: p(x) = a_N*x^N + ... + a_1*x + a_0.
- Uses a fully pipelined Horner chain of ORDER multiply-accumulate stages, with valid tagging, global stall and saturation reporting.
- Next-generation replacement for the fixed 2nd-order DDS polynomial datapath. Sits between the phase/segment lookup (x argument plus coefficient set) and the DDS output stage.
- Accepts one sample per cycle.

Parameters:
- DATA_WIDTH, 16: width of x, every coefficient, every accumulator and the output.
- ORDER, 2: polynomial order N, range 1..8. The coefficient bus carries ORDER+1 words.
- I_widthX, 2: integer bits of x, signed. Fraction bits FX = DATA_WIDTH-I_widthX.
- I_widthCoef, 7: integer bits of every coefficient, signed. FC = DATA_WIDTH-I_widthCoef.
- I_widthOut, 6: integer bits of the accumulators and evaluation_out. FO = DATA_WIDTH-I_widthOut.

Ports:
- clk_in, input, 1: single clock, rising edge.
- rst_in, input, 1: synchronous, active-high reset.
- enable, input, 1: pipeline advance. When low, every register holds.
- in_valid, input, 1: x_argu and coef_in hold a sample this cycle.
- x_argu, input, DATA_WIDTH: signed x, Q(I_widthX).(FX).
- coef_in, input, (ORDER+1)*DATA_WIDTH: packed coefficients. a_k is in slice [k*DATA_WIDTH +: DATA_WIDTH], signed, Q(I_widthCoef).(FC).
- out_valid, output, 1: evaluation_out holds a result.
- evaluation_out, output, DATA_WIDTH: signed p(x), Q(I_widthOut).(FO).
- sat_out, output, 1: at least one saturation occurred anywhere in this sample's chain.

Behaviour:
- Reset: rst_in=1 at a rising edge clears all pipeline registers. out_valid=0, evaluation_out=0, sat_out=0. Reset has priority over enable.
- Reset mid-operation: every in-flight sample is discarded. No out_valid is asserted for a sample accepted before reset.
- Stage 0 (load register):
  - Captures x, coefficients a_0..a_{N-1} and in_valid.
  - Sets acc_0 = a_N converted from FC to FO fraction bits. This is an arithmetic shift, rounded half-up if FC>FO, then saturated to the DATA_WIDTH signed range. sat_0 is set on clip.
- Stage k (k=1..N): acc_k = sat(round(acc_{k-1} * x, FX) + align(a_{N-k})).
  - The product is full 2*DATA_WIDTH signed.
  - round(.,FX): add 2^(FX-1), then arithmetic shift right by FX (round half toward +inf).
  - align(a): a shifted to FO fraction bits, same rounding as stage 0.
  - The sum is formed at DATA_WIDTH+2 bits, then saturated to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - sat_k = sat_{k-1} OR (clip in this stage).
- x, the remaining coefficients, valid and sat travel with the sample through per-stage delay registers. Each stage sees only its own sample's data.
- Latency: ORDER+1 enabled clock edges from the edge sampling in_valid=1 to the edge raising out_valid with that sample's result. Throughput is 1 sample per enabled cycle.
- evaluation_out and sat_out update only with valid samples. On bubbles (in_valid=0) they hold their last valid value, and out_valid follows the bubble (0).
- enable=0: no register changes, including valid bits. Outputs are stable. No samples are lost or duplicated. enable is sampled every cycle and is independent of in_valid.
- Coefficient and x inputs are don't-care when in_valid=0, but they are still clocked through. No X may reach evaluation_out through a valid-gated path.
- Build-time check: ORDER outside 1..8, or any I_width* >= DATA_WIDTH, is flagged as an elaboration error.

Test Plan (DATA_WIDTH=16, I_widthX=2, I_widthCoef=7, I_widthOut=6, so FX=14, FC=9, FO=10):
- Basic, ORDER=2: x=0x2000 (0.5), a2=0x0200 (1.0), a1=0x0400 (2.0), a0=0x0600 (3.0), in_valid=1 for one cycle. Required: out_valid=1 exactly 3 cycles later, evaluation_out=0x1100 (4.25), sat_out=0.
- Negative x, ORDER=2: x=0xC000 (-1.0), a2=0x0200, a1=0, a0=0. Required: evaluation_out=0x0400 (+1.0), sat_out=0.
- Rounding, ORDER=1: a1=0x0200, a0=0, x=0x0018. Required: evaluation_out=0x0002 (1.5 LSB rounded up). Then x=0xFFE8. Required: evaluation_out=0xFFFF (-1.5 LSB rounds to -1).
- Saturation, ORDER=2: x=0x2000, a2=0, a1=0, a0=0x5000 (40.0). Required: evaluation_out=0x7FFF, sat_out=1. With a0=0xB000 (-40.0), required: 0x8000, sat_out=1.
- Streaming plus stall: 6 back-to-back samples (x=0x0000,0x1000,...,0x5000, first test's coefficients), enable dropped for 2 cycles mid-stream. Required: 6 results in order, matching the golden Horner model bit-exact. out_valid is held through the stall with outputs frozen. Total cycles = 3 + 6 + 2 - 1.
- Reset mid-flight: issue 2 samples, assert rst_in for 1 cycle before the first completes. Required: out_valid stays 0 for those samples, evaluation_out=0, sat_out=0. A sample issued after reset returns a correct result at latency 3.

Source files
------------

// File: rtl/poly_horner_pipe_if.sv
// -----------------------------------------------------------------------------
// poly_horner_pipe_if
// Sample and result bundle for the pipelined Horner polynomial evaluator.
//   enable         : pipeline advance; low freezes every register
//   in_valid       : x_argu / coef_in carry a sample this cycle
//   x_argu         : signed x argument
//   coef_in        : packed coefficients, a_k at [k*DATA_WIDTH +: DATA_WIDTH]
//   out_valid      : evaluation_out carries a fresh result
//   evaluation_out : signed p(x)
//   sat_out        : some stage clipped while evaluating this result
// master = sample source / result sink, slave = evaluator.
// -----------------------------------------------------------------------------
interface poly_horner_pipe_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ORDER      = 2
);
  logic                            enable;
  logic                            in_valid;
  logic [DATA_WIDTH-1:0]           x_argu;
  logic [(ORDER+1)*DATA_WIDTH-1:0] coef_in;
  logic                            out_valid;
  logic [DATA_WIDTH-1:0]           evaluation_out;
  logic                            sat_out;

  modport master (
    output enable, in_valid, x_argu, coef_in,
    input  out_valid, evaluation_out, sat_out
  );

  modport slave (
    input  enable, in_valid, x_argu, coef_in,
    output out_valid, evaluation_out, sat_out
  );
endinterface

// File: rtl/poly_horner_pipe.sv
// -----------------------------------------------------------------------------
// poly_horner_pipe
// Fixed-point polynomial evaluator p(x) = a_N*x^N + ... + a_0 built as a fully
// pipelined Horner chain: a load stage, ORDER multiply-accumulate stages and an
// output register. One sample per enabled cycle, latency ORDER+1 enabled edges.
//   clk_in : rising-edge clock
//   rst_in : synchronous active-high reset, wins over enable
//   bus    : slave side of poly_horner_pipe_if (enable, sample in, result out)
// Formats: x is Q(I_widthX), coefficients Q(I_widthCoef), accumulators and the
// result Q(I_widthOut), all DATA_WIDTH wide and signed.
// -----------------------------------------------------------------------------
module poly_horner_pipe #(
  parameter int DATA_WIDTH  = 16,
  parameter int ORDER       = 2,
  parameter int I_widthX    = 2,
  parameter int I_widthCoef = 7,
  parameter int I_widthOut  = 6
) (
  input logic               clk_in,
  input logic               rst_in,
  poly_horner_pipe_if.slave bus
);
  localparam int W  = DATA_WIDTH;
  localparam int N  = ORDER;
  localparam int FX = DATA_WIDTH - I_widthX;
  localparam int FC = DATA_WIDTH - I_widthCoef;
  localparam int FO = DATA_WIDTH - I_widthOut;
  // Wide enough that product, rounding and coefficient alignment never wrap,
  // so saturation sees the exact mathematical sum.
  localparam int WW = 2 * W + 2;
  // Coefficient alignment is either a plain left shift or a rounded right shift.
  localparam int SHL    = (FO >= FC) ? FO - FC : 0;
  localparam int SHR    = (FC > FO) ? FC - FO : 0;
  localparam int SHR_M1 = (SHR > 0) ? SHR - 1 : 0;

  typedef logic signed [W-1:0]  word_t;
  typedef logic signed [WW-1:0] wide_t;
  typedef struct packed {
    logic         clip;
    logic [W-1:0] val;
  } sat_t;

  localparam wide_t MAXV  = {{(WW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam wide_t MINV  = {{(WW-W+1){1'b1}}, {(W-1){1'b0}}};
  localparam wide_t RND_X = wide_t'(1) << (FX - 1);
  localparam wide_t RND_A = (SHR > 0) ? (wide_t'(1) << SHR_M1) : '0;

  if (ORDER < 1 || ORDER > 8 || I_widthX >= DATA_WIDTH ||
      I_widthCoef >= DATA_WIDTH || I_widthOut >= DATA_WIDTH) begin : g_param_check
    $error("poly_horner_pipe: ORDER must be 1..8 and every I_width* below DATA_WIDTH");
  end

  function automatic wide_t sext(input word_t v);
    return {{(WW-W){v[W-1]}}, v};
  endfunction

  // Coefficient moved from FC to FO fraction bits, rounding half up.
  function automatic wide_t align(input word_t a);
    return ((sext(a) <<< SHL) + RND_A) >>> SHR;
  endfunction

  function automatic sat_t clip_to_word(input wide_t v);
    sat_t r;
    if (v > MAXV) begin
      r.clip = 1'b1;
      r.val  = MAXV[W-1:0];
    end else if (v < MINV) begin
      r.clip = 1'b1;
      r.val  = MINV[W-1:0];
    end else begin
      r.clip = 1'b0;
      r.val  = v[W-1:0];
    end
    return r;
  endfunction

  // One Horner step: sat(round(acc * x, FX) + align(a)).
  function automatic sat_t mac(input word_t acc, input word_t x, input word_t a);
    wide_t prod;
    prod = sext(acc) * sext(x);
    return clip_to_word(((prod + RND_X) >>> FX) + align(a));
  endfunction

  // Stage k register set: acc_q[k], valid_q[k], sat_q[k]. x_q[k] and coef_q[k]
  // are the sample's x and low coefficients delayed to line up with acc_q[k].
  word_t acc_q   [N+1];
  logic  valid_q [N+1];
  logic  sat_q   [N+1];
  word_t x_q     [N];
  word_t coef_q  [N][N];

  logic  out_valid_q;
  word_t eval_q;
  logic  sat_out_q;

  sat_t head;
  sat_t stage_res [N];

  always_comb begin
    // NOTE: every variable written here is fully assigned on every pass, so no
    // latch can be inferred; new combinational outputs need the same treatment.
    head = clip_to_word(align(word_t'(bus.coef_in[N*W +: W])));
    for (int k = 1; k <= N; k++) begin
      stage_res[k-1] = mac(acc_q[k-1], x_q[k-1], coef_q[k-1][N-k]);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      // NOTE: data registers are cleared along with the valid bits so nothing
      // undefined is ever clocked toward evaluation_out after reset.
      for (int k = 0; k <= N; k++) begin
        acc_q[k]   <= '0;
        valid_q[k] <= 1'b0;
        sat_q[k]   <= 1'b0;
      end
      for (int k = 0; k < N; k++) begin
        x_q[k] <= '0;
        for (int i = 0; i < N; i++) coef_q[k][i] <= '0;
      end
      out_valid_q <= 1'b0;
      eval_q      <= '0;
      sat_out_q   <= 1'b0;
    end else if (bus.enable) begin
      // NOTE: non-blocking assignments make every stage read its neighbour's
      // value from before this edge, which is what keeps samples apart.
      valid_q[0] <= bus.in_valid;
      acc_q[0]   <= head.val;
      sat_q[0]   <= head.clip;
      x_q[0]     <= bus.x_argu;
      for (int i = 0; i < N; i++) coef_q[0][i] <= word_t'(bus.coef_in[i*W +: W]);

      for (int k = 1; k <= N; k++) begin
        valid_q[k] <= valid_q[k-1];
        acc_q[k]   <= stage_res[k-1].val;
        sat_q[k]   <= sat_q[k-1] | stage_res[k-1].clip;
      end
      for (int k = 1; k < N; k++) begin
        x_q[k] <= x_q[k-1];
        for (int i = 0; i < N; i++) coef_q[k][i] <= coef_q[k-1][i];
      end

      // Result registers only move on valid samples; bubbles leave them holding.
      out_valid_q <= valid_q[N];
      if (valid_q[N]) begin
        eval_q    <= acc_q[N];
        sat_out_q <= sat_q[N];
      end
    end
  end

  assign bus.out_valid      = out_valid_q;
  assign bus.evaluation_out = eval_q;
  assign bus.sat_out        = sat_out_q;
endmodule
